// File: rtl/wisc_ctrl_pkg.sv
// Shared types and defaults for the execute-stage flow controller.
package wisc_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 3;
    localparam int unsigned PC_W_DEF       = 16;
    localparam int unsigned STALL_CNT_W    = 16;
    localparam int unsigned FLUSH_CNT_W    = 3;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StRedir = 2'd1,
        StHalt  = 2'd2
    } flow_state_e;

endpackage

// File: rtl/ex_flow_ctrl_if.sv
// Hazard/resolution inputs and pipeline-control outputs of the flow controller.
interface ex_flow_ctrl_if #(
    parameter int unsigned REG_ADDR_W = wisc_ctrl_pkg::REG_ADDR_W_DEF,
    parameter int unsigned PC_W       = wisc_ctrl_pkg::PC_W_DEF
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_rs_used;
    logic                  id_rt_used;
    logic                  ex_valid;
    logic                  ex_reg_wr;
    logic                  ex_mem_rd;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  mem_valid;
    logic                  mem_reg_wr;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  ex_redirect;
    logic [PC_W-1:0]       ex_target;
    logic                  ex_halt;
    logic                  mem_busy;

    logic                  pc_we;
    logic                  ifid_we;
    logic                  exmem_we;
    logic                  idex_bubble;
    logic                  ifid_flush;
    logic                  pc_sel;
    logic [PC_W-1:0]       redirect_pc;
    logic                  halted;
    logic [15:0]           stall_cnt;

    // Pipeline side: drives hazard/resolution info, receives controls.
    modport master (
        output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        output ex_valid, ex_reg_wr, ex_mem_rd, ex_rd,
        output mem_valid, mem_reg_wr, mem_rd,
        output ex_redirect, ex_target, ex_halt, mem_busy,
        input  pc_we, ifid_we, exmem_we, idex_bubble, ifid_flush, pc_sel,
        input  redirect_pc, halted, stall_cnt
    );

    // Controller side.
    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
        input  ex_valid, ex_reg_wr, ex_mem_rd, ex_rd,
        input  mem_valid, mem_reg_wr, mem_rd,
        input  ex_redirect, ex_target, ex_halt, mem_busy,
        output pc_we, ifid_we, exmem_we, idex_bubble, ifid_flush, pc_sel,
        output redirect_pc, halted, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW hazard detection between decode sources and EX/MEM destinations.
// EX_FWD_EN defined: forwarding exists, only load-use stalls.
module hazard_detect
    import wisc_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic                  ex_valid,
    input  logic                  ex_reg_wr,
    input  logic                  ex_mem_rd,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  mem_valid,
    input  logic                  mem_reg_wr,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  hazard_stall
);

    logic ex_match;
    logic mem_match;
    logic load_use;

    // Register 0 is an ordinary register, so no zero-specifier exemption.
    assign ex_match  = (id_rs_used && (id_rs == ex_rd))  || (id_rt_used && (id_rt == ex_rd));
    assign mem_match = (id_rs_used && (id_rs == mem_rd)) || (id_rt_used && (id_rt == mem_rd));
    assign load_use  = ex_valid && ex_reg_wr && ex_mem_rd && ex_match;

`ifdef EX_FWD_EN
    logic unused_mem;
    assign unused_mem   = mem_valid ^ mem_reg_wr ^ mem_match;
    assign hazard_stall = id_valid && load_use;
`else
    assign hazard_stall = id_valid && (load_use
                                       || (ex_valid && ex_reg_wr && ex_match)
                                       || (mem_valid && mem_reg_wr && mem_match));
`endif

endmodule

// File: rtl/ex_flow_ctrl.sv
// Execute-stage flow controller: enables, bubbles, redirect flush and halt sequencing.
// Optional macro EX_FWD_EN selects forwarding-aware hazard detection.
module ex_flow_ctrl
    import wisc_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
    parameter int unsigned PC_W         = PC_W_DEF,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ex_flow_ctrl_if.slave  bus
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    flow_state_e            state_q;
    logic [FLUSH_CNT_W-1:0] flush_cnt_q;
    logic [PC_W-1:0]        redirect_pc_q;
    logic [15:0]            stall_cnt_q;
    logic                   halted_q;

    logic hazard_stall;
    logic do_halt;
    logic do_redirect;
    logic first_redir;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_valid     (bus.id_valid),
        .id_rs        (bus.id_rs),
        .id_rt        (bus.id_rt),
        .id_rs_used   (bus.id_rs_used),
        .id_rt_used   (bus.id_rt_used),
        .ex_valid     (bus.ex_valid),
        .ex_reg_wr    (bus.ex_reg_wr),
        .ex_mem_rd    (bus.ex_mem_rd),
        .ex_rd        (bus.ex_rd),
        .mem_valid    (bus.mem_valid),
        .mem_reg_wr   (bus.mem_reg_wr),
        .mem_rd       (bus.mem_rd),
        .hazard_stall (hazard_stall)
    );

    assign do_halt     = bus.ex_valid && bus.ex_halt;
    assign do_redirect = bus.ex_valid && bus.ex_redirect;
    // The counter only leaves its initial value once a REDIR cycle completes unstalled.
    assign first_redir = (flush_cnt_q == FLUSH_INIT);

    always_comb begin
        bus.pc_we       = 1'b1;
        bus.ifid_we     = 1'b1;
        bus.exmem_we    = 1'b1;
        bus.idex_bubble = 1'b0;
        bus.ifid_flush  = 1'b0;
        bus.pc_sel      = 1'b0;
        if (bus.mem_busy) begin
            bus.pc_we    = 1'b0;
            bus.ifid_we  = 1'b0;
            bus.exmem_we = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (do_halt || (!do_redirect && hazard_stall)) begin
                        bus.pc_we       = 1'b0;
                        bus.ifid_we     = 1'b0;
                        bus.idex_bubble = 1'b1;
                    end else if (do_redirect) begin
                        bus.ifid_flush  = 1'b1;
                        bus.idex_bubble = 1'b1;
                    end
                end
                StRedir: begin
                    bus.ifid_flush  = 1'b1;
                    bus.idex_bubble = 1'b1;
                    bus.pc_sel      = first_redir;
                end
                StHalt: begin
                    bus.pc_we       = 1'b0;
                    bus.ifid_we     = 1'b0;
                    bus.idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRun;
            flush_cnt_q   <= '0;
            redirect_pc_q <= '0;
            stall_cnt_q   <= '0;
            halted_q      <= 1'b0;
        end else if (!bus.mem_busy) begin
            unique case (state_q)
                StRun: begin
                    if (do_halt) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (do_redirect) begin
                        state_q       <= StRedir;
                        redirect_pc_q <= bus.ex_target;
                        flush_cnt_q   <= FLUSH_INIT;
                    end else if (hazard_stall && (stall_cnt_q != STALL_CNT_MAX)) begin
                        stall_cnt_q <= stall_cnt_q + 16'd1;
                    end
                end
                StRedir: begin
                    if (flush_cnt_q == '0) begin
                        state_q <= StRun;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - 1'b1;
                    end
                end
                StHalt: ;
                default: state_q <= StRun;
            endcase
        end
    end

    assign bus.redirect_pc = redirect_pc_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_ex_flow_ctrl.sv
// Directed and randomized bench for ex_flow_ctrl against a cycle-level reference model.
module tb_ex_flow_ctrl;

    localparam int F     = 2;
    localparam int MRUN  = 0;
    localparam int MREDR = 1;
    localparam int MHALT = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_flow_ctrl_if #(.REG_ADDR_W(3), .PC_W(16)) bus ();

    ex_flow_ctrl #(
        .REG_ADDR_W   (3),
        .PC_W         (16),
        .FLUSH_CYCLES (F)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode, number of REDIR cycles already completed, target, stall count.
    int          m_mode;
    int          m_done;
    logic [15:0] m_target;
    int          m_stall;

    // Outputs captured at the most recent model-checked sample point.
    logic o_pc_we, o_ifid_we, o_exmem_we, o_bubble, o_flush, o_pc_sel, o_halted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode   = MRUN;
        m_done   = 0;
        m_target = 16'h0;
        m_stall  = 0;
    endtask

    task automatic set_idle();
        bus.id_valid    = 1'b0;
        bus.id_rs       = 3'd0;
        bus.id_rt       = 3'd0;
        bus.id_rs_used  = 1'b0;
        bus.id_rt_used  = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_reg_wr   = 1'b0;
        bus.ex_mem_rd   = 1'b0;
        bus.ex_rd       = 3'd0;
        bus.mem_valid   = 1'b0;
        bus.mem_reg_wr  = 1'b0;
        bus.mem_rd      = 3'd0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 16'h0;
        bus.ex_halt     = 1'b0;
        bus.mem_busy    = 1'b0;
    endtask

    task automatic rand_inputs(input bit allow_halt);
        bus.id_valid    = ($urandom_range(0, 3) != 0);
        bus.id_rs       = 3'($urandom_range(0, 7));
        bus.id_rt       = 3'($urandom_range(0, 7));
        bus.id_rs_used  = 1'($urandom_range(0, 1));
        bus.id_rt_used  = 1'($urandom_range(0, 1));
        bus.ex_valid    = ($urandom_range(0, 3) != 0);
        bus.ex_reg_wr   = 1'($urandom_range(0, 1));
        bus.ex_mem_rd   = 1'($urandom_range(0, 1));
        bus.ex_rd       = 3'($urandom_range(0, 7));
        bus.mem_valid   = 1'($urandom_range(0, 1));
        bus.mem_reg_wr  = 1'($urandom_range(0, 1));
        bus.mem_rd      = 3'($urandom_range(0, 7));
        bus.ex_redirect = ($urandom_range(0, 9) == 0);
        bus.ex_target   = 16'($urandom);
        bus.ex_halt     = allow_halt && ($urandom_range(0, 49) == 0);
        bus.mem_busy    = ($urandom_range(0, 6) == 0);
    endtask

    function automatic bit reads(input logic [2:0] r);
        return (bus.id_rs_used && bus.id_rs == r) || (bus.id_rt_used && bus.id_rt == r);
    endfunction

    function automatic bit want_stall();
        if (!bus.id_valid) return 1'b0;
`ifdef EX_FWD_EN
        return bus.ex_valid && bus.ex_reg_wr && bus.ex_mem_rd && reads(bus.ex_rd);
`else
        return (bus.ex_valid && bus.ex_reg_wr && reads(bus.ex_rd))
            || (bus.mem_valid && bus.mem_reg_wr && reads(bus.mem_rd));
`endif
    endfunction

    // One clock: compare all outputs at the falling edge, then advance the model at the rise.
    task automatic cycle();
        bit e_pc, e_ifid, e_exmem, e_bub, e_fl, e_ps;
        int n_mode, n_done, n_stall;
        logic [15:0] n_target;
        @(negedge clk);
        e_pc = 1; e_ifid = 1; e_exmem = 1; e_bub = 0; e_fl = 0; e_ps = 0;
        n_mode = m_mode; n_done = m_done; n_stall = m_stall; n_target = m_target;
        if (bus.mem_busy) begin
            e_pc = 0; e_ifid = 0; e_exmem = 0;
        end else if (m_mode == MHALT) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
        end else if (m_mode == MREDR) begin
            e_fl = 1; e_bub = 1; e_ps = (m_done == 0);
            n_done = m_done + 1;
            if (n_done == F) n_mode = MRUN;
        end else if (bus.ex_valid && bus.ex_halt) begin
            e_pc = 0; e_ifid = 0; e_bub = 1; n_mode = MHALT;
        end else if (bus.ex_valid && bus.ex_redirect) begin
            e_fl = 1; e_bub = 1; n_target = bus.ex_target; n_mode = MREDR; n_done = 0;
        end else if (want_stall()) begin
            e_pc = 0; e_ifid = 0; e_bub = 1;
            if (m_stall < 65535) n_stall = m_stall + 1;
        end
        o_pc_we = bus.pc_we; o_ifid_we = bus.ifid_we; o_exmem_we = bus.exmem_we;
        o_bubble = bus.idex_bubble; o_flush = bus.ifid_flush; o_pc_sel = bus.pc_sel;
        o_halted = bus.halted;
        chk("pc_we", 32'(bus.pc_we), 32'(e_pc));
        chk("ifid_we", 32'(bus.ifid_we), 32'(e_ifid));
        chk("exmem_we", 32'(bus.exmem_we), 32'(e_exmem));
        chk("idex_bubble", 32'(bus.idex_bubble), 32'(e_bub));
        chk("ifid_flush", 32'(bus.ifid_flush), 32'(e_fl));
        chk("pc_sel", 32'(bus.pc_sel), 32'(e_ps));
        chk("halted", 32'(bus.halted), 32'(m_mode == MHALT));
        chk("redirect_pc", 32'(bus.redirect_pc), 32'(m_target));
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        @(posedge clk);
        #1;
        m_mode = n_mode; m_done = n_done; m_stall = n_stall; m_target = n_target;
    endtask

    initial begin
        set_idle();
        model_reset();
        #23;
        chk("rst_pc_we", 32'(bus.pc_we), 32'd1);
        chk("rst_exmem_we", 32'(bus.exmem_we), 32'd1);
        chk("rst_bubble", 32'(bus.idex_bubble), 32'd0);
        chk("rst_redirect_pc", 32'(bus.redirect_pc), 32'h0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) cycle();

        // Load r3 in EX, decode reads r3.
        bus.id_valid = 1; bus.id_rs = 3'd3; bus.id_rs_used = 1;
        bus.ex_valid = 1; bus.ex_reg_wr = 1; bus.ex_mem_rd = 1; bus.ex_rd = 3'd3;
        cycle();
        chk("lu_bubble", 32'(o_bubble), 32'd1);
        chk("lu_cnt", 32'(bus.stall_cnt), 32'd1);
        bus.ex_valid = 0; bus.mem_valid = 1; bus.mem_reg_wr = 1; bus.mem_rd = 3'd3;
        cycle();
        set_idle();
        cycle();
`ifdef EX_FWD_EN
        chk("lu_total", 32'(bus.stall_cnt), 32'd1);
`else
        chk("lu_total", 32'(bus.stall_cnt), 32'd2);
`endif

        // ALU write r3 in EX, decode reads r3 via rt.
        bus.id_valid = 1; bus.id_rt = 3'd3; bus.id_rt_used = 1;
        bus.ex_valid = 1; bus.ex_reg_wr = 1; bus.ex_rd = 3'd3;
        cycle();
        bus.ex_valid = 0; bus.mem_valid = 1; bus.mem_reg_wr = 1; bus.mem_rd = 3'd3;
        cycle();
        set_idle();
        cycle();
`ifdef EX_FWD_EN
        chk("alu_total", 32'(bus.stall_cnt), 32'd1);
`else
        chk("alu_total", 32'(bus.stall_cnt), 32'd4);
`endif

        // Redirect to 0x0040; a wrong-path redirect during REDIR must be ignored.
        bus.ex_valid = 1; bus.ex_redirect = 1; bus.ex_target = 16'h0040;
        cycle();
        chk("redir_t_flush", 32'(o_flush), 32'd1);
        chk("redir_t_pcsel", 32'(o_pc_sel), 32'd0);
        bus.ex_target = 16'h0099;
        cycle();
        chk("redir_t1_pcsel", 32'(o_pc_sel), 32'd1);
        chk("redir_t1_pc", 32'(bus.redirect_pc), 32'h0040);
        set_idle();
        cycle();
        chk("redir_t2_flush", 32'(o_flush), 32'd1);
        chk("redir_t2_pcsel", 32'(o_pc_sel), 32'd0);
        cycle();
        chk("redir_t3_flush", 32'(o_flush), 32'd0);
        chk("redir_t3_pc_we", 32'(o_pc_we), 32'd1);

        // mem_busy for 3 cycles in the first REDIR cycle.
        bus.ex_valid = 1; bus.ex_redirect = 1; bus.ex_target = 16'h1234;
        cycle();
        set_idle();
        bus.mem_busy = 1;
        repeat (3) begin
            cycle();
            chk("busy_exmem_we", 32'(o_exmem_we), 32'd0);
            chk("busy_pcsel", 32'(o_pc_sel), 32'd0);
        end
        bus.mem_busy = 0;
        cycle();
        chk("busy_resume_pcsel", 32'(o_pc_sel), 32'd1);
        cycle();
        chk("busy_resume_flush", 32'(o_flush), 32'd1);
        cycle();
        chk("busy_back_run", 32'(o_flush), 32'd0);

        // Randomized traffic without halts.
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b0);
            cycle();
        end

        // Reset asserted in the middle of REDIR.
        set_idle();
        bus.ex_valid = 1; bus.ex_redirect = 1; bus.ex_target = 16'hBEEF;
        cycle();
        set_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_redirect_pc", 32'(bus.redirect_pc), 32'h0);
        chk("midrst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("midrst_flush", 32'(bus.ifid_flush), 32'd0);
        chk("midrst_pcsel", 32'(bus.pc_sel), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle();

        // Hold a hazard long enough to saturate the stall counter.
        bus.id_valid = 1; bus.id_rs = 3'd1; bus.id_rs_used = 1;
        bus.ex_valid = 1; bus.ex_reg_wr = 1; bus.ex_mem_rd = 1; bus.ex_rd = 3'd1;
        repeat (65540) @(posedge clk);
        #1;
        m_stall = 65535;
        chk("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);
        cycle();
        chk("stall_sat_hold", 32'(bus.stall_cnt), 32'hFFFF);

        // Halt and redirect in the same cycle: halt wins.
        set_idle();
        bus.ex_valid = 1; bus.ex_halt = 1; bus.ex_redirect = 1; bus.ex_target = 16'h0777;
        cycle();
        chk("halt_t_pcsel", 32'(o_pc_sel), 32'd0);
        chk("halt_t_flush", 32'(o_flush), 32'd0);
        set_idle();
        cycle();
        chk("halt_halted", 32'(o_halted), 32'd1);
        chk("halt_pcsel", 32'(o_pc_sel), 32'd0);
        for (int i = 0; i < 30; i++) begin
            rand_inputs(1'b1);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_flow_ctrl.md
# ex_flow_ctrl

Pipeline flow controller for the execute stage: decides each cycle whether the PC, IF/ID and EX/MEM registers advance, when a bubble enters ID/EX, and when the PC is redirected to a target resolved by execute (branch/jump `newPC`). It sits beside the execute stage and consumes its resolution signals plus decode/memory hazard information. It also owns halt sequencing and a saturating hazard-stall counter.

## Interface
Parameters:
- `REG_ADDR_W`, 3, register specifier width
- `PC_W`, 16, PC/target width
- `FLUSH_CYCLES`, 2, cycles spent in REDIR (legal 1..7)

Ports:
- `clk`  in  1  clock; all state on rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `id_valid`  in  1  decode holds a valid instruction
- `id_rs`, `id_rt`  in  REG_ADDR_W  decode source specifiers
- `id_rs_used`, `id_rt_used`  in  1  source actually read
- `ex_valid`, `ex_reg_wr`, `ex_mem_rd`  in  1  EX instruction valid / writes reg / is load
- `ex_rd`  in  REG_ADDR_W  EX destination
- `mem_valid`, `mem_reg_wr`  in  1  MEM instruction valid / writes reg
- `mem_rd`  in  REG_ADDR_W  MEM destination
- `ex_redirect`  in  1  taken branch or jump resolved in EX
- `ex_target`  in  PC_W  resolved target (execute `newPC`)
- `ex_halt`  in  1  HALT in EX
- `mem_busy`  in  1  data memory not ready
- `pc_we`, `ifid_we`, `exmem_we`  out  1  register enables (1 = advance)
- `idex_bubble`  out  1  load NOP into ID/EX
- `ifid_flush`  out  1  load NOP into IF/ID
- `pc_sel`  out  1  PC loads `redirect_pc`
- `redirect_pc`  out  PC_W  registered target
- `halted`  out  1  processor halted
- `stall_cnt`  out  16  saturating count of hazard-stall cycles

## Operation
- States: RUN, REDIR, HALT. Reset: RUN, flush counter 0, `redirect_pc`=0, `stall_cnt`=0.
- Output reset/idle values (RUN, no event): `pc_we`=`ifid_we`=`exmem_we`=1; `idex_bubble`=`ifid_flush`=`pc_sel`=`halted`=0.
- Priority per cycle: `mem_busy` > halt > redirect > data hazard.
- `mem_busy`=1 (any state): all three enables 0, no bubble/flush, `pc_sel`=0, state and counter frozen, `redirect_pc` held, `stall_cnt` unchanged.
- Halt: RUN with `ex_valid`&`ex_halt` → `pc_we`=`ifid_we`=0, `idex_bubble`=1 this cycle; next state HALT. HALT: `pc_we`=`ifid_we`=0, `idex_bubble`=1, `exmem_we`=1, `halted`=1; exit only by reset.
- Redirect: RUN with `ex_valid`&`ex_redirect` → `ifid_flush`=1, `idex_bubble`=1, `redirect_pc`←`ex_target`, counter←FLUSH_CYCLES−1, next REDIR.
- REDIR: `ifid_flush`=`idex_bubble`=1; `pc_sel`=1 only on first REDIR cycle; counter decrements; leave to RUN the cycle after counter reaches 0. `ex_redirect` in REDIR is ignored (wrong-path bubble).
- Data hazard (RUN, no higher event), `id_valid`=1, match = used source equals destination:
  - load-use: `ex_valid`&`ex_reg_wr`&`ex_mem_rd`&match(`ex_rd`).
  - stall: `pc_we`=`ifid_we`=0, `idex_bubble`=1; state stays RUN; `stall_cnt`+1 saturating at 0xFFFF.
- Register 0 is a normal register (no zero-register exemption).

## Timing
- Enables/bubble/flush combinational from inputs and state, same cycle.
- Redirect latency: EX resolves in cycle t; PC loads target at end of t+1 (`pc_sel`=1 in t+1).
- Load-use stall lasts exactly 1 cycle with forwarding.
- Reset asserted mid-REDIR/HALT: immediate return to RUN, all registers to reset values.

## Configuration
- `EX_FWD_EN` defined: forwarding present; only load-use hazard stalls.
- Undefined: also stall on `ex_valid`&`ex_reg_wr`&match(`ex_rd`) and on `mem_valid`&`mem_reg_wr`&match(`mem_rd`); RAW stall up to 2 cycles. `mem_*` inputs unused when defined.

## Structure
- Package `wisc_ctrl_pkg`: state encoding (RUN/REDIR/HALT), `REG_ADDR_W`, `PC_W` defaults, `STALL_CNT_MAX`.
- Sub-module `hazard_detect`: combinational source/destination comparison producing `hazard_stall`; FSM, counter and registers in top.

## Test plan
- Reset release, idle inputs → enables 1, others 0, `stall_cnt`=0, `redirect_pc`=0.
- EX load r3, ID `add` uses rs=r3 → 1 stall cycle, `idex_bubble`=1, `stall_cnt`=1; with `EX_FWD_EN` undefined, ALU write r3 → 2 stall cycles.
- `ex_redirect`, `ex_target`=0x0040, FLUSH_CYCLES=2 → flush/bubble cycles t,t+1,t+2; `pc_sel`=1 only at t+1, `redirect_pc`=0x0040; RUN at t+3.
- `mem_busy` held 3 cycles during REDIR → all enables 0, counter frozen, REDIR resumes with remaining cycles.
- `ex_halt` and `ex_redirect` same cycle → HALT entered, `halted`=1 next cycle, `pc_sel` never 1.
- `rst_n` low mid-REDIR → immediate RUN, `redirect_pc`=0, `stall_cnt`=0.
